// File: rtl/vend_dispense_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vend_dispense_ctrl
// Purpose  : Queues product/change pulses and sequences motor/hopper
//            handshakes with inventory tracking, refunds and ack timeouts.
// Revision : 1.0
// ============================================================================
module vend_dispense_ctrl #(
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 10,
    parameter int QDEPTH     = 4,
    parameter int ACK_TO     = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       pr_i,
    input  logic                       ch_i,
    output logic                       motor_req,
    input  logic                       motor_ack,
    output logic                       hopper_req,
    input  logic                       hopper_ack,
    output logic                       refund,
    input  logic                       refill_i,
    input  logic [STOCK_W-1:0]         refill_cnt,
    input  logic                       clr_i,
    output logic [STOCK_W-1:0]         stock,
    output logic                       sold_out,
    output logic [$clog2(QDEPTH):0]    pending,
    output logic                       busy,
    output logic                       fault,
    output logic                       overflow
);

    localparam int c_PTR_W = $clog2(QDEPTH);
    localparam int c_TMR_W = $clog2(ACK_TO + 1);

    localparam logic [c_PTR_W:0]   c_FULL     = QDEPTH[c_PTR_W:0];
    localparam logic [c_TMR_W-1:0] c_TO_LAST  = c_TMR_W'(ACK_TO - 1);
    localparam logic [STOCK_W-1:0] c_STK_INIT = STOCK_W'(STOCK_INIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MOTOR  = 2'd1,
        S_HOPPER = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_motor_req;
    logic                 r_hopper_req;
    logic                 r_refund;
    logic                 r_busy;
    logic                 r_fault;
    logic                 r_overflow;
    logic                 r_cur_ch;
    logic [c_TMR_W-1:0]   r_tmr;
    logic [STOCK_W-1:0]   r_stock;

    logic [1:0]           r_q [QDEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_PTR_W:0]     r_count;

    logic                 w_push_req;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_ovf;
    logic [1:0]           w_head;
    logic                 w_dec;

    // ------------------------------------------------------------------
    // Pending-transaction queue; a pop in IDLE frees a slot for a
    // same-cycle push even when full.
    // ------------------------------------------------------------------
    assign w_push_req = pr_i | ch_i;
    assign w_full     = (r_count == c_FULL);
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf      = w_push_req && w_full && !w_pop;
    assign w_head     = r_q[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q[r_wptr] <= {pr_i, ch_i};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_overflow <= 1'b0;
        end else if (w_ovf) begin
            r_overflow <= 1'b1;
        end else if (clr_i) begin
            r_overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Inventory: refill beats a dispense decrement in the same cycle.
    // ------------------------------------------------------------------
    assign w_dec = (r_state == S_MOTOR) && motor_ack && (r_stock != '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_stock <= c_STK_INIT;
        end else if (refill_i) begin
            r_stock <= refill_cnt;
        end else if (w_dec) begin
            r_stock <= r_stock - STOCK_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Dispense sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_motor_req  <= 1'b0;
            r_hopper_req <= 1'b0;
            r_refund     <= 1'b0;
            r_busy       <= 1'b0;
            r_fault      <= 1'b0;
            r_cur_ch     <= 1'b0;
            r_tmr        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_tmr  <= '0;
                        r_busy <= 1'b1;
                        if (w_head[1] && (r_stock != '0)) begin
                            r_state     <= S_MOTOR;
                            r_motor_req <= 1'b1;
                            r_cur_ch    <= w_head[0];
                        end else begin
                            // Out-of-stock product becomes a full refund;
                            // its change bit is irrelevant.
                            r_state      <= S_HOPPER;
                            r_hopper_req <= 1'b1;
                            r_refund     <= w_head[1];
                            r_cur_ch     <= 1'b0;
                        end
                    end
                end

                S_MOTOR: begin
                    if (motor_ack) begin
                        r_motor_req <= 1'b0;
                        r_tmr       <= '0;
                        if (r_cur_ch) begin
                            r_state      <= S_HOPPER;
                            r_hopper_req <= 1'b1;
                            r_refund     <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (r_tmr == c_TO_LAST) begin
                        r_state     <= S_FAULT;
                        r_motor_req <= 1'b0;
                        r_fault     <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr + c_TMR_W'(1);
                    end
                end

                S_HOPPER: begin
                    if (hopper_ack) begin
                        r_state      <= S_IDLE;
                        r_hopper_req <= 1'b0;
                        r_refund     <= 1'b0;
                        r_busy       <= 1'b0;
                    end else if (r_tmr == c_TO_LAST) begin
                        r_state      <= S_FAULT;
                        r_hopper_req <= 1'b0;
                        r_refund     <= 1'b0;
                        r_fault      <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr + c_TMR_W'(1);
                    end
                end

                S_FAULT: begin
                    if (clr_i) begin
                        r_state <= S_IDLE;
                        r_fault <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_motor_req  <= 1'b0;
                    r_hopper_req <= 1'b0;
                    r_refund     <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign motor_req  = r_motor_req;
    assign hopper_req = r_hopper_req;
    assign refund     = r_refund;
    assign busy       = r_busy;
    assign fault      = r_fault;
    assign overflow   = r_overflow;
    assign stock      = r_stock;
    assign sold_out   = (r_stock == '0);
    assign pending    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_vend_dispense_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_dispense_ctrl
// Purpose  : Directed self-checking bench for vend_dispense_ctrl.
// Revision : 1.0
// ============================================================================
module tb_vend_dispense_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic       pr, ch, mack, hack, refill, clr;
    logic [3:0] refill_cnt;
    logic       motor_req, hopper_req, refund, sold_out, busy, fault, overflow;
    logic [3:0] stock;
    logic [2:0] pending;

    int n_chk  = 0;
    int n_fail = 0;

    vend_dispense_ctrl #(
        .STOCK_W    (4),
        .STOCK_INIT (10),
        .QDEPTH     (4),
        .ACK_TO     (16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .pr_i       (pr),
        .ch_i       (ch),
        .motor_req  (motor_req),
        .motor_ack  (mack),
        .hopper_req (hopper_req),
        .hopper_ack (hack),
        .refund     (refund),
        .refill_i   (refill),
        .refill_cnt (refill_cnt),
        .clr_i      (clr),
        .stock      (stock),
        .sold_out   (sold_out),
        .pending    (pending),
        .busy       (busy),
        .fault      (fault),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Advance past one rising edge; inputs change and outputs are read here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rstn = 1'b0; pr = 1'b0; ch = 1'b0; mack = 1'b0; hack = 1'b0;
        refill = 1'b0; clr = 1'b0; refill_cnt = 4'd0;
        tick();
        tick();
        chk("rst_stock",    int'(stock), 10);
        chk("rst_sold_out", int'(sold_out), 0);
        chk("rst_pending",  int'(pending), 0);
        chk("rst_busy",     int'(busy), 0);
        chk("rst_mreq",     int'(motor_req), 0);
        chk("rst_hreq",     int'(hopper_req), 0);
        chk("rst_refund",   int'(refund), 0);
        chk("rst_fault",    int'(fault), 0);
        chk("rst_ovf",      int'(overflow), 0);
        rstn = 1'b1;
        tick();

        // Single product, ack three cycles after request
        pr = 1'b1;
        tick();
        pr = 1'b0;
        chk("t1_pending1", int'(pending), 1);
        chk("t1_mreq_lat0", int'(motor_req), 0);
        tick();
        chk("t1_mreq_up", int'(motor_req), 1);
        chk("t1_pending0", int'(pending), 0);
        chk("t1_busy", int'(busy), 1);
        tick();
        tick();
        mack = 1'b1;
        tick();
        mack = 1'b0;
        chk("t1_mreq_down", int'(motor_req), 0);
        chk("t1_stock", int'(stock), 9);
        chk("t1_hreq", int'(hopper_req), 0);
        chk("t1_idle", int'(busy), 0);
        tick();
        chk("t1_hreq_after", int'(hopper_req), 0);

        // Product plus change in the same cycle
        pr = 1'b1; ch = 1'b1;
        tick();
        pr = 1'b0; ch = 1'b0;
        chk("t2_pending", int'(pending), 1);
        tick();
        chk("t2_mreq", int'(motor_req), 1);
        mack = 1'b1;
        tick();
        mack = 1'b0;
        chk("t2_mreq_down", int'(motor_req), 0);
        chk("t2_hreq_up", int'(hopper_req), 1);
        chk("t2_refund", int'(refund), 0);
        chk("t2_stock", int'(stock), 8);
        hack = 1'b1;
        tick();
        hack = 1'b0;
        chk("t2_hreq_down", int'(hopper_req), 0);
        chk("t2_idle", int'(busy), 0);

        // Sold out -> refund
        refill = 1'b1; refill_cnt = 4'd0;
        tick();
        refill = 1'b0;
        chk("t3_stock0", int'(stock), 0);
        chk("t3_sold_out", int'(sold_out), 1);
        pr = 1'b1;
        tick();
        pr = 1'b0;
        tick();
        chk("t3_hreq", int'(hopper_req), 1);
        chk("t3_refund", int'(refund), 1);
        chk("t3_mreq", int'(motor_req), 0);
        hack = 1'b1;
        tick();
        hack = 1'b0;
        chk("t3_hreq_down", int'(hopper_req), 0);
        chk("t3_stock_kept", int'(stock), 0);

        // Motor timeout, queue while faulted, then clear
        refill = 1'b1; refill_cnt = 4'd10;
        tick();
        refill = 1'b0;
        chk("t4_refill", int'(stock), 10);
        pr = 1'b1;
        tick();
        pr = 1'b0;
        tick();
        chk("t4_mreq", int'(motor_req), 1);
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        chk("t4_no_fault_yet", int'(fault), 0);
        chk("t4_mreq_held", int'(motor_req), 1);
        tick();
        chk("t4_fault", int'(fault), 1);
        chk("t4_mreq_off", int'(motor_req), 0);
        chk("t4_hreq_off", int'(hopper_req), 0);
        pr = 1'b1;
        tick();
        pr = 1'b0; ch = 1'b1;
        tick();
        ch = 1'b0;
        chk("t4_pending_f", int'(pending), 2);
        chk("t4_fault_held", int'(fault), 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t4_fault_clr", int'(fault), 0);
        chk("t4_pending_clr", int'(pending), 2);
        chk("t4_stock_nodec", int'(stock), 10);
        tick();
        chk("t4_first_mreq", int'(motor_req), 1);
        chk("t4_pending1", int'(pending), 1);
        mack = 1'b1;
        tick();
        mack = 1'b0;
        chk("t4_stock9", int'(stock), 9);
        chk("t4_no_hreq", int'(hopper_req), 0);
        tick();
        chk("t4_second_hreq", int'(hopper_req), 1);
        chk("t4_second_refund", int'(refund), 0);
        chk("t4_pending0", int'(pending), 0);
        hack = 1'b1;
        tick();
        hack = 1'b0;
        chk("t4_done", int'(busy), 0);

        // Overflow while blocked in MOTOR, refill racing the ack
        pr = 1'b1;
        tick();
        pr = 1'b0;
        tick();
        chk("t5_mreq", int'(motor_req), 1);
        pr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        pr = 1'b0;
        chk("t5_pending", int'(pending), 4);
        chk("t5_overflow", int'(overflow), 1);
        refill = 1'b1; refill_cnt = 4'd7; mack = 1'b1;
        tick();
        refill = 1'b0; mack = 1'b0;
        chk("t5_stock7", int'(stock), 7);
        chk("t5_mreq_down", int'(motor_req), 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t5_ovf_clr", int'(overflow), 0);
        chk("t5_pending3", int'(pending), 3);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        // Reset in the middle of a hopper handshake
        refill = 1'b1; refill_cnt = 4'd3;
        tick();
        refill = 1'b0;
        ch = 1'b1;
        tick();
        ch = 1'b0;
        tick();
        chk("t6_hreq", int'(hopper_req), 1);
        pr = 1'b1;
        tick();
        pr = 1'b0;
        chk("t6_pending1", int'(pending), 1);
        chk("t6_stock3", int'(stock), 3);
        rstn = 1'b0;
        tick();
        chk("t6_hreq_rst", int'(hopper_req), 0);
        chk("t6_pending_rst", int'(pending), 0);
        chk("t6_stock_rst", int'(stock), 10);
        chk("t6_busy_rst", int'(busy), 0);
        rstn = 1'b1;
        tick();
        tick();
        chk("t6_no_mreq", int'(motor_req), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vend_dispense_ctrl.md
# vend_dispense_ctrl

Dispense sequencer that sits between `vending_machine` and the physical actuators. It captures the one-cycle product (`pr`) and change (`ch`) pulses from the vending core into a small queue. It then drives the product motor and the change hopper with request/acknowledge handshakes, one transaction at a time. It tracks inventory, converts a product request into a refund when stock is zero, and detects actuator timeouts.

## Interface
- `STOCK_W`, 4: inventory counter width; stock saturates at 2^STOCK_W-1.
- `STOCK_INIT`, 10: stock value loaded at reset.
- `QDEPTH`, 4: pending-transaction queue depth; power of 2, at least 2.
- `ACK_TO`, 16: cycles a request may stay high without ack before fault.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rstn`  in  1  reset. Synchronous, active-low.
- `pr_i`  in  1  product pulse from vending core.
- `ch_i`  in  1  change pulse from vending core; may coincide with `pr_i`.
- `motor_req`  out  1  product motor request.
- `motor_ack`  in  1  motor done.
- `hopper_req`  out  1  hopper request.
- `hopper_ack`  in  1  hopper done.
- `refund`  out  1  qualifies `hopper_req`: refund of full price rather than change.
- `refill_i`  in  1  one-cycle pulse that loads stock.
- `refill_cnt`  in  STOCK_W  stock value loaded by `refill_i`.
- `clr_i`  in  1  clears fault and overflow.
- `stock`  out  STOCK_W  current inventory.
- `sold_out`  out  1  high when `stock` is 0.
- `pending`  out  $clog2(QDEPTH)+1  queue occupancy.
- `busy`  out  1  high when the state is not IDLE.
- `fault`  out  1  actuator timeout, sticky.
- `overflow`  out  1  queue overflow, sticky.

## Operation
- Queue entry is {pr, ch}.
  - Push on any sampled cycle with `pr_i|ch_i`.
  - Push when full: entry dropped, `overflow` set. A pop in the same cycle frees a slot, so the push succeeds.
- States:
  - IDLE:
    - Queue empty: stay.
    - Otherwise pop the head.
    - pr=1 and stock>0: go to MOTOR.
    - pr=1 and stock=0: go to HOPPER with `refund`=1; the ch bit is ignored.
    - pr=0, ch=1: go to HOPPER with `refund`=0.
  - MOTOR:
    - `motor_req`=1.
    - On sampled `motor_ack`: stock decrements by 1. Next state is HOPPER (`refund`=0) if the entry's ch=1, else IDLE.
  - HOPPER:
    - `hopper_req`=1. `refund` holds the value latched on entry.
    - On sampled `hopper_ack`: go to IDLE.
  - FAULT:
    - All requests are 0; `fault`=1.
    - Queue keeps accepting pushes.
    - `clr_i`: go to IDLE. The faulted entry is discarded.
- Timeout:
  - The counter clears on entry to MOTOR or HOPPER and increments each cycle the request is high without ack.
  - On reaching ACK_TO with no ack: go to FAULT.
  - Ack sampled in the same cycle the count reaches ACK_TO: the ack wins.
- Acks sampled while the corresponding request is 0 are ignored.
- `refill_i`: stock loads `refill_cnt` in any state. It takes priority over a decrement in the same cycle.
- `clr_i`: clears `overflow` in any state.
- `sold_out` is derived combinationally from the `stock` register.

## Timing
- Reset values:
  - state IDLE; queue empty.
  - `motor_req`, `hopper_req`, `refund`, `busy`, `fault`, `overflow` all 0.
  - `pending`=0; `stock`=STOCK_INIT.
  - `sold_out`=(STOCK_INIT==0).
- Reset mid-handshake drops requests the next cycle and discards the queue.
- Latency:
  - `pr_i` sampled at edge t: `pending` increments at t+1, and `motor_req` rises after edge t+1 when the controller is idle.
  - `motor_ack` sampled at edge k: `motor_req` is 0 and `stock` is decremented after k. `hopper_req` rises in the same cycle when ch=1, with no gap.
  - IDLE holds at least one cycle between transactions.
- Requests hold steady until ack or timeout; the actuator may hold ack longer.
- `pending` counts queued entries only and excludes the entry in service.

## Test plan
- STOCK_INIT=10, pulse `pr_i`; ack motor 3 cycles after req -> `motor_req` rises 2 cycles after the pulse, `stock`=9, `hopper_req` never asserts.
- `pr_i`+`ch_i` in the same cycle -> motor handshake, then `hopper_req`=1 with `refund`=0 immediately after the ack, `stock` decrements by 1.
- Refill with `refill_cnt`=0, then `pr_i` -> `sold_out`=1, `hopper_req`=1 with `refund`=1, `motor_req` stays 0, `stock` stays 0.
- Hold the motor ack low -> `fault`=1 after ACK_TO cycles of request, requests at 0. Queue 2 pulses while faulted, then `clr_i` -> `pending`=2, both served in order.
- Push 6 pulses while blocked in MOTOR with QDEPTH=4 -> `pending`=4, `overflow`=1. Refill coinciding with `motor_ack` and `refill_cnt`=7 -> `stock`=7.
- Assert `rstn`=0 mid-HOPPER -> `hopper_req`=0 and `pending`=0 at the next edge, `stock`=STOCK_INIT.
